// File: rtl/huge_page_manager.sv
// huge_page_manager: ping-pong huge page arming, qword accounting and header/close handshake
module huge_page_manager (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_wr_en,
  input  logic [1:0]  reg_wr_addr,
  input  logic [31:0] reg_wr_data,
  input  logic        change_huge_page,
  input  logic        send_last_tlp_change_huge_page,
  input  logic        tlp_sent,
  input  logic [8:0]  tlp_qwords,
  output logic        change_huge_page_ack,
  output logic        page_valid,
  output logic [63:0] tlp_wr_addr,
  output logic        hdr_wr_req,
  output logic [63:0] hdr_wr_addr,
  output logic [18:0] hdr_wr_qwords,
  input  logic        hdr_wr_ack
);
  typedef enum logic [2:0] {IDLE, WAIT_LAST, HDR, SWITCH, WAIT_PAGE, ACK, HOLD} state_t;
  state_t            state_q, state_d;
  logic [1:0][63:0]  base_q, base_d;
  logic [1:0]        armed_q, armed_d;
  logic              active_q, active_d;
  logic [18:0]       cnt_q, cnt_d;
  logic              pg;
  logic [18:0]       cnt_add;
  assign pg = reg_wr_addr[1];
  assign cnt_add = cnt_q + {10'd0, tlp_qwords};
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    armed_d  = armed_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    if (reg_wr_en && !armed_q[pg]) begin
      if (reg_wr_addr[0]) begin
        base_d[pg][63:32] = reg_wr_data;
        armed_d[pg]       = 1'b1;
      end else begin
        base_d[pg][31:0] = reg_wr_data;
      end
    end
    case (state_q)
      IDLE: begin
        cnt_d   = tlp_sent ? cnt_add : cnt_q;
        state_d = send_last_tlp_change_huge_page ? WAIT_LAST : change_huge_page ? HDR : IDLE;
      end
      WAIT_LAST: begin
        cnt_d   = tlp_sent ? cnt_add : cnt_q;
        state_d = tlp_sent ? HDR : WAIT_LAST;
      end
      HDR:       state_d = hdr_wr_ack ? SWITCH : HDR;
      SWITCH: begin
        armed_d[active_q] = 1'b0;
        active_d          = !active_q;
        cnt_d             = 19'd16;
        state_d           = WAIT_PAGE;
      end
      WAIT_PAGE: state_d = armed_q[active_q] ? ACK : WAIT_PAGE;
      ACK:       state_d = HOLD;
      HOLD:      state_d = (change_huge_page || send_last_tlp_change_huge_page) ? HOLD : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      armed_q  <= '0;
      active_q <= 1'b0;
      cnt_q    <= 19'd16;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      armed_q  <= armed_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end
  assign page_valid           = armed_q[active_q];
  assign tlp_wr_addr          = base_q[active_q] + {42'd0, cnt_q, 3'b000};
  assign change_huge_page_ack = state_q == ACK;
  assign hdr_wr_req           = state_q == HDR;
  assign hdr_wr_addr          = hdr_wr_req ? base_q[active_q] : 64'd0;
  assign hdr_wr_qwords        = hdr_wr_req ? cnt_q : 19'd0;
endmodule

// File: tb/tb_huge_page_manager.sv
// tb_huge_page_manager: directed vectors for huge_page_manager
module tb_huge_page_manager;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_wr_en = 1'b0;
  logic [1:0]  reg_wr_addr = '0;
  logic [31:0] reg_wr_data = '0;
  logic        change_huge_page = 1'b0;
  logic        send_last_tlp_change_huge_page = 1'b0;
  logic        tlp_sent = 1'b0;
  logic [8:0]  tlp_qwords = '0;
  logic        change_huge_page_ack;
  logic        page_valid;
  logic [63:0] tlp_wr_addr;
  logic        hdr_wr_req;
  logic [63:0] hdr_wr_addr;
  logic [18:0] hdr_wr_qwords;
  logic        hdr_wr_ack = 1'b0;
  int          vecs = 0;
  int          errs = 0;
  int          acks;
  int          hdrs;
  huge_page_manager dut (
    .clk(clk),
    .reset(reset),
    .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .change_huge_page(change_huge_page),
    .send_last_tlp_change_huge_page(send_last_tlp_change_huge_page),
    .tlp_sent(tlp_sent),
    .tlp_qwords(tlp_qwords),
    .change_huge_page_ack(change_huge_page_ack),
    .page_valid(page_valid),
    .tlp_wr_addr(tlp_wr_addr),
    .hdr_wr_req(hdr_wr_req),
    .hdr_wr_addr(hdr_wr_addr),
    .hdr_wr_qwords(hdr_wr_qwords),
    .hdr_wr_ack(hdr_wr_ack)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_wr_en = 1'b1;
    reg_wr_addr = a;
    reg_wr_data = d;
    tick();
    reg_wr_en = 1'b0;
  endtask
  task automatic tlps(input int n, input logic [8:0] q);
    for (int i = 0; i < n; i++) begin
      tlp_sent = 1'b1;
      tlp_qwords = q;
      tick();
    end
    tlp_sent = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      acks += int'(change_huge_page_ack);
      hdrs += int'(hdr_wr_req);
    end
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 64'(page_valid), 64'd0);
    check("rst_addr", tlp_wr_addr, 64'h80);
    check("rst_ack", 64'(change_huge_page_ack), 64'd0);
    check("rst_hreq", 64'(hdr_wr_req), 64'd0);
    check("rst_haddr", hdr_wr_addr, 64'd0);
    check("rst_hqw", 64'(hdr_wr_qwords), 64'd0);
    wr(2'd0, 32'h1000_0000);
    check("low_only_valid", 64'(page_valid), 64'd0);
    wr(2'd1, 32'h0000_0001);
    check("arm_valid", 64'(page_valid), 64'd1);
    check("arm_addr", tlp_wr_addr, 64'h1_1000_0080);
    wr(2'd0, 32'hdead_beef);
    wr(2'd1, 32'h0000_0005);
    check("protect_addr", tlp_wr_addr, 64'h1_1000_0080);
    tlps(3, 9'd16);
    check("accum_addr", tlp_wr_addr, 64'h1_1000_0200);
    wr(2'd2, 32'h2000_0000);
    wr(2'd3, 32'h0000_0002);
    check("hp1_not_active", tlp_wr_addr, 64'h1_1000_0200);
    change_huge_page = 1'b1;
    tick();
    check("chg_hreq", 64'(hdr_wr_req), 64'd1);
    check("chg_haddr", hdr_wr_addr, 64'h1_1000_0000);
    check("chg_hqw", 64'(hdr_wr_qwords), 64'd64);
    tlps(1, 9'd7);
    check("hdr_ignore_tlp", 64'(hdr_wr_qwords), 64'd64);
    check("hdr_hold", 64'(hdr_wr_req), 64'd1);
    hdr_wr_ack = 1'b1;
    tick();
    hdr_wr_ack = 1'b0;
    check("hreq_drop", 64'(hdr_wr_req), 64'd0);
    acks = 0;
    hdrs = 0;
    run(5);
    check("chg_new_addr", tlp_wr_addr, 64'h2_2000_0080);
    change_huge_page = 1'b0;
    run(2);
    check("chg_one_ack", 64'(acks), 64'd1);
    check("chg_no_rehdr", 64'(hdrs), 64'd0);
    tlps(3, 9'd16);
    wr(2'd0, 32'h3000_0000);
    wr(2'd1, 32'h0000_0003);
    check("hp0_rearm_valid", tlp_wr_addr, 64'h2_2000_0200);
    send_last_tlp_change_huge_page = 1'b1;
    tick();
    hdr_wr_ack = 1'b1;
    tick();
    hdr_wr_ack = 1'b0;
    tick();
    check("sl_no_hdr", 64'(hdr_wr_req), 64'd0);
    send_last_tlp_change_huge_page = 1'b0;
    tlps(1, 9'd5);
    check("sl_hreq", 64'(hdr_wr_req), 64'd1);
    check("sl_hqw", 64'(hdr_wr_qwords), 64'd69);
    check("sl_haddr", hdr_wr_addr, 64'h2_2000_0000);
    hdr_wr_ack = 1'b1;
    tick();
    hdr_wr_ack = 1'b0;
    acks = 0;
    run(4);
    check("sl_one_ack", 64'(acks), 64'd1);
    check("sl_new_addr", tlp_wr_addr, 64'h3_3000_0080);
    change_huge_page = 1'b1;
    tick();
    hdr_wr_ack = 1'b1;
    tick();
    hdr_wr_ack = 1'b0;
    change_huge_page = 1'b0;
    acks = 0;
    run(4);
    check("starve_valid", 64'(page_valid), 64'd0);
    check("starve_no_ack", 64'(acks), 64'd0);
    wr(2'd2, 32'h4000_0000);
    check("starve_low_ack", 64'(change_huge_page_ack), 64'd0);
    wr(2'd3, 32'h0000_0004);
    check("starve_w1_ack", 64'(change_huge_page_ack), 64'd0);
    check("starve_w1_valid", 64'(page_valid), 64'd1);
    tick();
    check("starve_w2_ack", 64'(change_huge_page_ack), 64'd1);
    tick();
    check("starve_after_ack", 64'(change_huge_page_ack), 64'd0);
    check("starve_addr", tlp_wr_addr, 64'h4_4000_0080);
    tick();
    change_huge_page = 1'b1;
    tick();
    check("rst_mid_hreq", 64'(hdr_wr_req), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    change_huge_page = 1'b0;
    check("rst_mid_hreq0", 64'(hdr_wr_req), 64'd0);
    check("rst_mid_valid", 64'(page_valid), 64'd0);
    check("rst_mid_addr", tlp_wr_addr, 64'h80);
    check("rst_mid_haddr", hdr_wr_addr, 64'd0);
    acks = 0;
    hdrs = 0;
    hdr_wr_ack = 1'b1;
    run(1);
    hdr_wr_ack = 1'b0;
    run(4);
    check("rst_mid_no_ack", 64'(acks), 64'd0);
    check("rst_mid_no_hdr", 64'(hdrs), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
